sar_adc_ctrl: RTL and testbench

//   Successive-approximation controller that digitises the output of an upstream amplifier stage.
//   The amplifier drives a sample/hold. The hold output is compared against an external

---
 rtl/sar_adc_ctrl_if.sv | 33 +++
 rtl/sar_adc_ctrl.sv | 132 +++++++++++++
 tb/tb_sar_adc_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_ctrl_if.sv
// SAR ADC controller bus: start/comparator in,
// sample/DAC code/status/result out.
interface sar_adc_ctrl_if #(
  parameter int NBITS = 8
);
  logic             start;
  logic             cmp;
  logic             sample;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             valid;
  logic [NBITS-1:0] result;

  modport master (
    output start,
    output cmp,
    input  sample,
    input  dac_code,
    input  busy,
    input  valid,
    input  result
  );

  modport slave (
    input  start,
    input  cmp,
    output sample,
    output dac_code,
    output busy,
    output valid,
    output result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller.
// Samples, resolves one bit per SETTLE cycles MSB first.
module sar_adc_ctrl #(
  parameter int NBITS  = 8,
  parameter int SAMPLE = 4,
  parameter int SETTLE = 2
) (
  input logic          clk,
  input logic          rst,
  sar_adc_ctrl_if.slave bus
);
  localparam int CMAX = (SAMPLE > SETTLE) ? SAMPLE : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NBITS);

  typedef logic [NBITS-1:0] code_t;
  typedef enum logic [1:0] {
    IDLE,
    SAMP,
    TRIAL,
    DONE
  } state_t;

  localparam code_t ONE = code_t'(1);

  state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  code_t   w_q, w_d;
  code_t   dac_q, dac_d;
  code_t   result_q, result_d;
  logic    sample_q, sample_d;
  logic    busy_q, busy_d;
  logic    valid_q, valid_d;
  code_t   w_set;

  // Work register with the current bit replaced by the comparator.
  always_comb begin
    w_set = w_q;
    w_set[idx_q] = bus.cmp;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    w_d      = w_q;
    dac_d    = dac_q;
    result_d = result_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = SAMP;
          cnt_d    = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          dac_d    = '0;
        end else begin
          state_d  = IDLE;
          sample_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      SAMP: begin
        if (cnt_q == CW'(SAMPLE - 1)) begin
          state_d  = TRIAL;
          cnt_d    = '0;
          idx_d    = IW'(NBITS - 1);
          w_d      = '0;
          sample_d = 1'b0;
          dac_d    = ONE << (NBITS - 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRIAL: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d = '0;
          w_d   = w_set;
          if (idx_q == '0) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            result_d = w_set;
            dac_d    = w_set;
          end else begin
            idx_d = idx_q - IW'(1);
            dac_d = w_set | (ONE << (idx_q - IW'(1)));
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= IW'(NBITS - 1);
      w_q      <= '0;
      dac_q    <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.sample   = sample_q;
  assign bus.dac_code = dac_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.result   = result_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomized bench for sar_adc_ctrl against a
// binary-search reference model.
module tb_sar_adc_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.NBITS(8)) if0 ();
  sar_adc_ctrl_if #(.NBITS(4)) if1 ();

  sar_adc_ctrl #(
    .NBITS(8), .SAMPLE(4), .SETTLE(2)
  ) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  sar_adc_ctrl #(
    .NBITS(4), .SAMPLE(1), .SETTLE(3)
  ) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  int total = 0;
  int bad   = 0;
  int vin0  = 0;
  int mode0 = 0;
  int exp_seq [16];
  int exp_res;

  always_comb begin
    case (mode0)
      1:       if0.cmp = 1'b1;
      2:       if0.cmp = 1'b0;
      default: if0.cmp = (vin0 >= int'(if0.dac_code));
    endcase
  end

  task automatic check(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cmpf(int mode, int vin, int code);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return vin >= code;
  endfunction

  // Ideal binary search: list of trial codes and final code.
  task automatic build(int n, int vin, int mode);
    int code;
    int trial;
    code = 0;
    for (int j = 0; j < n; j++) begin
      trial = code | (1 << (n - 1 - j));
      exp_seq[j] = trial;
      if (cmpf(mode, vin, trial)) code = trial;
    end
    exp_res = code;
  endtask

  // One 8-bit conversion; timing counted from start edge.
  task automatic conv8(int vin, int mode, bit noisy, bit hold);
    vin0  = vin;
    mode0 = mode;
    build(8, vin, mode);
    if0.start = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (hold) if0.start = 1'b1;
      else if (noisy) if0.start = 1'($urandom_range(0, 1));
      else if0.start = 1'b0;
      check("busy", int'(if0.busy), 1);
      check("valid_early", int'(if0.valid), 0);
      check("sample", int'(if0.sample), int'(c <= 4));
      if (c <= 4) check("dac_samp", int'(if0.dac_code), 0);
      else check("dac_trial", int'(if0.dac_code),
                 exp_seq[(c - 5) / 2]);
      tick();
    end
    if0.start = hold;
    check("valid", int'(if0.valid), 1);
    check("busy_done", int'(if0.busy), 0);
    check("sample_done", int'(if0.sample), 0);
    check("result", int'(if0.result), exp_res);
    check("dac_done", int'(if0.dac_code), exp_res);
    if (!hold) begin
      tick();
      check("valid_pulse", int'(if0.valid), 0);
      check("busy_idle", int'(if0.busy), 0);
      check("dac_hold", int'(if0.dac_code), exp_res);
      check("result_hold", int'(if0.result), exp_res);
    end
  endtask

  // One 4-bit conversion on the slow-settle instance.
  task automatic conv4(int vin, bit noisy);
    int j;
    int ph;
    build(4, vin, 0);
    if1.start = 1'b1;
    if1.cmp   = 1'b0;
    tick();
    if1.start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      j  = (c >= 2) ? (c - 2) / 3 : 0;
      ph = (c >= 2) ? (c - 2) % 3 : 0;
      if (c >= 2 && (ph == 2 || !noisy))
        if1.cmp = (vin >= exp_seq[j]);
      else
        if1.cmp = 1'($urandom_range(0, 1));
      check("b_busy", int'(if1.busy), 1);
      check("b_valid_early", int'(if1.valid), 0);
      check("b_sample", int'(if1.sample), int'(c == 1));
      check("b_dac", int'(if1.dac_code),
            (c == 1) ? 0 : exp_seq[j]);
      tick();
    end
    check("b_valid", int'(if1.valid), 1);
    check("b_busy_done", int'(if1.busy), 0);
    check("b_result", int'(if1.result), exp_res);
    tick();
    check("b_valid_pulse", int'(if1.valid), 0);
  endtask

  task automatic idle_zero(string tag);
    check({tag, "_sample"}, int'(if0.sample), 0);
    check({tag, "_busy"}, int'(if0.busy), 0);
    check({tag, "_valid"}, int'(if0.valid), 0);
    check({tag, "_dac"}, int'(if0.dac_code), 0);
    check({tag, "_result"}, int'(if0.result), 0);
  endtask

  initial begin
    rst = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if1.cmp   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    idle_zero("rst");
    check("rst_b_busy", int'(if1.busy), 0);
    check("rst_b_result", int'(if1.result), 0);

    conv8(153, 0, 1'b0, 1'b0);
    conv8(77, 1, 1'b0, 1'b0);
    conv8(77, 2, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++)
      conv8($urandom_range(0, 255), 0, 1'b0, 1'b1);
    conv8($urandom_range(0, 255), 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++)
      conv8($urandom_range(0, 255), 0, 1'b1, 1'b0);

    conv8(200, 0, 1'b0, 1'b0);
    vin0 = 99;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_zero("midrst");
    for (int c = 0; c < 25; c++) begin
      check("midrst_novalid", int'(if0.valid), 0);
      tick();
    end
    check("midrst_busy", int'(if0.busy), 0);
    conv8(99, 0, 1'b0, 1'b0);

    conv4(9, 1'b1);
    for (int k = 0; k < 4; k++)
      conv4($urandom_range(0, 15), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
